// File: rtl/bt_cmd_uart_seq.sv
`default_nettype none
// ============================================================================
// Module      : bt_cmd_uart_seq
// Description : Streams a ROM-held command out as 8N1 UART frames and flags
//               reception of the response terminator byte on RX.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_cmd_uart_seq #(
   parameter int         BAUD_DIV  = 2604,
   parameter logic [7:0] TERM_BYTE = 8'h0A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic [4:0] cmd_start,
   input  logic [3:0] cmd_len,
   output logic [4:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       TX,
   input  logic       RX,
   output logic       busy,
   output logic       resp_rcvd
);

   localparam int                 c_CNT_W     = $clog2(BAUD_DIV);
   localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(BAUD_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_BIT_EARLY = c_CNT_W'(BAUD_DIV - 2);
   localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(BAUD_DIV / 2 - 1);

   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_FETCH = 3'd1,
      TX_LOAD  = 3'd2,
      TX_SHIFT = 3'd3,
      TX_NEXT  = 3'd4
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   tx_state_t          r_tx_state, w_tx_next;
   logic [4:0]         r_addr;
   logic [3:0]         r_remaining;
   logic [9:0]         r_frame;
   logic [c_CNT_W-1:0] r_tx_cnt;
   logic [3:0]         r_tx_bit;

   logic w_start, w_tx_tick, w_tx_done;

   assign w_start   = send && (cmd_len != 4'd0);
   assign w_tx_tick = (r_tx_cnt == c_BIT_LAST);
   // Leave the stop bit one cycle early so NEXT/FETCH/LOAD leave a 2-cycle gap.
   assign w_tx_done = (r_tx_bit == 4'd9) && (r_tx_cnt == c_BIT_EARLY);

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (w_start) w_tx_next = TX_FETCH;
         TX_FETCH: w_tx_next = TX_LOAD;
         TX_LOAD:  w_tx_next = TX_SHIFT;
         TX_SHIFT: if (w_tx_done) w_tx_next = TX_NEXT;
         TX_NEXT:  w_tx_next = (r_remaining == 4'd1) ? TX_IDLE : TX_FETCH;
         default:  w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_tx_state <= TX_IDLE;
      else     r_tx_state <= w_tx_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= 5'd0;
         r_remaining <= 4'd0;
         r_frame     <= '1;
         r_tx_cnt    <= '0;
         r_tx_bit    <= 4'd0;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               if (w_start) begin
                  r_addr      <= cmd_start;
                  r_remaining <= cmd_len;
               end
            end
            TX_LOAD: begin
               r_frame  <= {1'b1, rom_data, 1'b0};
               r_tx_cnt <= '0;
               r_tx_bit <= 4'd0;
            end
            TX_SHIFT: begin
               if (w_tx_tick) begin
                  r_tx_cnt <= '0;
                  r_tx_bit <= r_tx_bit + 4'd1;
                  r_frame  <= {1'b1, r_frame[9:1]};
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            TX_NEXT: begin
               r_remaining <= r_remaining - 4'd1;
               r_addr      <= r_addr + 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign TX       = r_frame[0];
   assign busy     = (r_tx_state != TX_IDLE);
   assign rom_addr = r_addr;

   rx_state_t          r_rx_state, w_rx_next;
   logic               r_rx_meta, r_rx_sync, r_rx_last;
   logic [c_CNT_W-1:0] r_rx_cnt;
   logic [3:0]         r_rx_bit;
   logic [7:0]         r_rx_shift;
   logic               r_resp;

   logic w_rx_fall, w_rx_half, w_rx_tick;

   assign w_rx_fall = r_rx_last & ~r_rx_sync;
   assign w_rx_half = (r_rx_cnt == c_HALF_LAST);
   assign w_rx_tick = (r_rx_cnt == c_BIT_LAST);

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
         RX_START: if (w_rx_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 4'd7) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_rx_state <= RX_IDLE;
      else     r_rx_state <= w_rx_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_last  <= 1'b1;
         r_rx_cnt   <= '0;
         r_rx_bit   <= 4'd0;
         r_rx_shift <= 8'd0;
         r_resp     <= 1'b0;
      end else begin
         r_rx_meta <= RX;
         r_rx_sync <= r_rx_meta;
         r_rx_last <= r_rx_sync;
         r_resp    <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               r_rx_cnt <= '0;
               r_rx_bit <= 4'd0;
            end
            RX_START: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + 1'b1;
            RX_DATA: begin
               if (w_rx_tick) begin
                  r_rx_cnt   <= '0;
                  r_rx_bit   <= r_rx_bit + 4'd1;
                  r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (w_rx_tick) begin
                  r_rx_cnt <= '0;
                  r_resp   <= r_rx_sync && (r_rx_shift == TERM_BYTE);
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_rcvd = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_bt_cmd_uart_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_cmd_uart_seq
// Description : Scoreboard bench: decodes TX frames and resp_rcvd pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_cmd_uart_seq;

   localparam int c_BD   = 16;
   localparam int c_BYTE = 10 * c_BD + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       send = 1'b0;
   logic [4:0] cmd_start = 5'd0;
   logic [3:0] cmd_len = 4'd0;
   logic [4:0] rom_addr;
   logic [7:0] rom_data = 8'd0;
   logic       TX;
   logic       RX = 1'b1;
   logic       busy;
   logic       resp_rcvd;

   bt_cmd_uart_seq #(.BAUD_DIV(c_BD), .TERM_BYTE(8'h0A)) dut (
      .clk(clk), .rst(rst), .send(send), .cmd_start(cmd_start), .cmd_len(cmd_len),
      .rom_addr(rom_addr), .rom_data(rom_data), .TX(TX), .RX(RX),
      .busy(busy), .resp_rcvd(resp_rcvd)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_data <= 8'hA0 + {3'b000, rom_addr};

   typedef struct {
      logic [7:0] data;
      int         start;
   } exp_t;

   exp_t tx_q[$];
   int   rx_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Issues a command; the accepting edge k is the next posedge.
   task automatic send_cmd(input logic [4:0] st, input logic [3:0] len, output int k);
      exp_t e;
      @(negedge clk);
      send = 1'b1; cmd_start = st; cmd_len = len;
      k = cyc + 1;
      for (int j = 0; j < int'(len); j++) begin
         e.data  = 8'hA0 + {3'b000, 5'(int'(st) + j)};
         e.start = k + 2 + c_BYTE * j;
         tx_q.push_back(e);
      end
      @(negedge clk);
      send = 1'b0;
   endtask

   task automatic wait_idle(input int k, input int len, input string name);
      int lim;
      lim = cyc + c_BYTE * len + 50;
      while (busy !== 1'b0 && cyc < lim) @(negedge clk);
      check(name, cyc, k + c_BYTE * len);
   endtask

   task automatic rx_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      RX = 1'b0;
      if (b == 8'h0A && stop) rx_q.push_back(cyc + 155);
      for (int i = 0; i < 8; i++) begin
         repeat (c_BD) @(negedge clk);
         RX = b[i];
      end
      repeat (c_BD) @(negedge clk);
      RX = stop;
      repeat (c_BD) @(negedge clk);
      RX = 1'b1;
   endtask

   initial begin : tx_monitor
      logic [9:0] bits;
      int         s;
      bit         ab;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || TX !== 1'b0) continue;
         s = cyc; ab = 1'b0; bits = '1;
         for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < ((i == 0) ? c_BD / 2 : c_BD); j++) begin
               @(negedge clk);
               if (rst) ab = 1'b1;
            end
            if (ab) break;
            bits[i] = TX;
         end
         if (!ab) begin
            check("tx_start_bit", {31'd0, bits[0]}, 32'd0);
            check("tx_stop_bit", {31'd0, bits[9]}, 32'd1);
            if (tx_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL tx_unexpected_byte: got 0x%0h expected none (cycle %0d)", bits[8:1], s);
            end else begin
               e = tx_q.pop_front();
               check("tx_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
               check("tx_start_cycle", s, e.start);
            end
         end
      end
   end

   initial begin : rx_monitor
      forever begin
         @(negedge clk);
         if (resp_rcvd === 1'b1) begin
            if (rx_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL resp_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
               check("resp_cycle", cyc, rx_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int k, e_clr, n_err;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_tx", {31'd0, TX}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_resp", {31'd0, resp_rcvd}, 32'd0);
      check("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
      n_err = 0;
      repeat (200) begin
         @(negedge clk);
         if (TX !== 1'b1 || busy !== 1'b0 || resp_rcvd !== 1'b0) n_err++;
      end
      check("idle_quiet", n_err, 0);

      send_cmd(5'd0, 4'd6, k);
      wait_idle(k, 6, "busy_fall_6byte");
      repeat (5) @(negedge clk);

      send_cmd(5'd30, 4'd4, k);
      wait_idle(k, 4, "busy_fall_wrap");
      repeat (5) @(negedge clk);

      rx_byte(8'h4F, 1'b1);
      rx_byte(8'h4B, 1'b1);
      rx_byte(8'h0D, 1'b1);
      rx_byte(8'h0A, 1'b1);
      rx_byte(8'h0A, 1'b0);
      repeat (20) @(negedge clk);
      RX = 1'b0;
      repeat (3) @(negedge clk);
      RX = 1'b1;
      repeat (200) @(negedge clk);
      check("resp_pending", rx_q.size(), 0);

      send_cmd(5'd3, 4'd3, k);
      for (int p = 0; p < 40; p++) begin
         repeat (9) @(negedge clk);
         send = 1'b1; cmd_start = 5'd20; cmd_len = 4'd15;
         @(negedge clk);
         if (p % 10 == 0) check("busy_while_resend", {31'd0, busy}, 32'd1);
         send = 1'b0;
      end
      wait_idle(k, 3, "busy_fall_ignored_sends");

      send_cmd(5'd8, 4'd1, k);
      e_clr = k + c_BYTE;
      wait_until(e_clr - 1);
      send = 1'b1; cmd_start = 5'd12; cmd_len = 4'd1;
      @(negedge clk);
      check("send_at_busy_clear_ignored", {31'd0, busy}, 32'd0);
      begin
         exp_t e;
         e.data = 8'hAC; e.start = e_clr + 3;
         tx_q.push_back(e);
      end
      @(negedge clk);
      check("send_after_clear_taken", {31'd0, busy}, 32'd1);
      send = 1'b0;
      wait_idle(e_clr + 1, 1, "busy_fall_back_to_back");

      @(negedge clk);
      send = 1'b1; cmd_start = 5'd5; cmd_len = 4'd0;
      @(negedge clk);
      send = 1'b0;
      n_err = 0;
      repeat (300) begin
         @(negedge clk);
         if (busy !== 1'b0) n_err++;
      end
      check("len0_busy", n_err, 0);

      send_cmd(5'd0, 4'd6, k);
      wait_until(k + 2 + c_BYTE + 50);
      rst = 1'b1;
      @(negedge clk);
      check("abort_tx", {31'd0, TX}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_rom_addr", {27'd0, rom_addr}, 32'd0);
      rst = 1'b0;
      tx_q.delete();
      repeat (200) @(negedge clk);
      send_cmd(5'd10, 4'd2, k);
      wait_idle(k, 2, "busy_fall_after_abort");
      repeat (20) @(negedge clk);

      check("tx_queue_left", tx_q.size(), 0);
      check("rx_queue_left", rx_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
